adc_multich_capture: RTL and testbench
======================================

// Module: adc_multich_capture
// PURPOSE
//  N-channel oscilloscope capture engine; successor to the single-channel ADC-to-FIFO path.
//  Samples CH_NUM parallel ADC buses in the ADC_Clk domain and applies a programmable decimation.
//  Stores samples in a circular buffer with pre-trigger history and a level/edge trigger.
//  Once capture completes, streams the frame oldest-first over a valid/ready port to display/upload logic.
// PARAMETERS
//  DATA_W  8   bits per ADC sample (unsigned)
//  CH_NUM  4   channels; one buffer word = CH_NUM*DATA_W bits, all channels captured together
//  ADDR_W  10  buffer depth DEPTH = 2**ADDR_W words
//  SEL_W   2   width of trig_ch; must be >= max(1, clog2(CH_NUM))
// PORTS
//  ADC_Clk     in   1              sole clock; all logic on rising edge
//  Reset       in   1              asynchronous, active-high; forces IDLE
//  adc_data    in   CH_NUM*DATA_W  channel k at [k*DATA_W +: DATA_W]
//  adc_valid   in   1              sample strobe; data ignored when low
//  decim       in   16             keep 1 of every decim+1 valid samples (0 = keep all)
//  arm         in   1              pulse; starts a capture
//  trig_ch     in   SEL_W          channel compared against trig_level
//  trig_level  in   DATA_W         trigger threshold (unsigned)
//  trig_edge   in   1              0 = rising, 1 = falling
//  force_trig  in   1              pulse; triggers on the next kept sample while ARMED
//  pre_len     in   ADDR_W         pre-trigger samples; sampled at arm; clamped to DEPTH-1
//  rd_start    in   1              pulse; starts readout (accepted in DONE only)
//  rd_ready    in   1              downstream accepts rd_data
//  rd_data     out  CH_NUM*DATA_W  readout word
//  rd_valid    out  1              rd_data valid
//  rd_last     out  1              with rd_valid: final word of frame
//  busy        out  1              high in FILL/ARMED/POST/READ
//  done        out  1              high in DONE
//  trig_pos    out  ADDR_W         buffer address of trigger sample
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; decimation counter 0; write/read pointers 0.
//  Reset mid-capture or mid-readout aborts immediately; buffer contents are undefined.
//  Kept sample: adc_valid && dcnt==0. On adc_valid, dcnt <= (dcnt==0) ? decim : dcnt-1.
//   dcnt is also cleared on arm, so the first valid sample after arm is kept.
//  Trigger condition on a kept sample s, with prev = last kept sample on trig_ch:
//   rising = (prev < trig_level) && (s >= trig_level)
//   falling = (prev >= trig_level) && (s < trig_level)
//   There is no prev for the first kept sample after arm, so it never triggers.
//  Every kept sample in FILL/ARMED/POST is written at wr_ptr; wr_ptr then increments mod DEPTH.
//  FSM:
//   IDLE:  arm -> wr_ptr=0, cnt=0; go to FILL (or ARMED if clamped pre_len==0).
//   FILL:  each kept sample increments cnt; when cnt reaches pre_len -> ARMED.
//          Trigger and force_trig are ignored in FILL.
//   ARMED: trigger or latched force_trig on a kept sample:
//          write it, trig_pos <= its address, post = DEPTH-1-pre_len.
//          Go to POST, or to DONE if post==0. Otherwise keep overwriting the ring.
//   POST:  each kept sample decrements post; write of the last one -> DONE.
//   DONE:  done=1. arm -> re-capture as from IDLE. rd_start -> READ, rd_ptr = trig_pos-pre_len mod DEPTH.
//          If arm and rd_start arrive together, arm wins.
//   READ:  streams exactly DEPTH words from rd_ptr upward mod DEPTH.
//          First rd_valid 2 cycles after rd_start. rd_data is held stable while rd_valid && !rd_ready.
//          No bubbles while rd_ready stays high. rd_last is on word DEPTH-1; its handshake -> IDLE.
//  arm is ignored in FILL/ARMED/POST/READ; rd_start is ignored outside DONE.
//  force_trig outside ARMED is dropped (not latched).
//  Buffer memory uses synchronous read, latency 1; output uses a skid register for backpressure.
// TESTING
//  1. decim=0, pre_len=4, rising, level=0x80, ramp 0x00..0xFF on ch0, then rd_start, ready=1
//     -> trig_pos=0x080 addr; words 5..DEPTH after pre-history; first rd_data ch0=0x7C; rd_last on word 1024.
//  2. decim=3, constant-rising ramp +1 per valid -> stored ch0 values step by 4.
//  3. Falling trigger on ch3 only; ch0-2 cross level -> trigger only on ch3 crossing; trig_pos matches.
//  4. force_trig in FILL ignored; force_trig in ARMED -> trigger on next kept sample even with flat input.
//  5. Readout with rd_ready toggled 1/0 every cycle -> rd_data stable while stalled; 1024 words exactly;
//     no loss or duplication.
//  6. Reset asserted mid-POST -> next cycle busy=0, done=0, rd_valid=0; fresh arm restarts cleanly;
//     arm held during READ has no effect.

Source files
------------

// File: rtl/adc_multich_capture.sv
// adc_multich_capture
//   Multi-channel oscilloscope capture engine. CH_NUM parallel ADC buses are
//   sampled together and thinned by a programmable decimator. Kept samples go
//   into a circular buffer that keeps pre-trigger history. A level/edge trigger
//   (or a forced trigger) selects the frame. After capture the frame streams out
//   oldest-first over a valid/ready port.
//
// Ports
//   ADC_Clk      clock; everything runs on its rising edge
//   Reset        asynchronous, active-high; returns to IDLE
//   adc_data     channel k at [k*DATA_W +: DATA_W]
//   adc_valid    sample strobe
//   decim        keep 1 of every decim+1 valid samples
//   arm          pulse; start a capture (accepted in IDLE / DONE)
//   trig_ch      channel compared against trig_level
//   trig_level   unsigned trigger threshold
//   trig_edge    0 = rising, 1 = falling
//   force_trig   pulse; trigger on the next kept sample while ARMED
//   pre_len      number of pre-trigger samples, sampled at arm
//   rd_start     pulse; start readout (accepted in DONE)
//   rd_ready     downstream accepts rd_data
//   rd_data      readout word
//   rd_valid     rd_data valid
//   rd_last      final word of the frame (qualified by rd_valid)
//   busy         high in FILL / ARMED / POST / READ
//   done         high in DONE
//   trig_pos     buffer address of the trigger sample
`timescale 1ns/1ps
module adc_multich_capture #(
  parameter int DATA_W = 8,
  parameter int CH_NUM = 4,
  parameter int ADDR_W = 10,
  parameter int SEL_W  = 2
) (
  input  logic                     ADC_Clk,
  input  logic                     Reset,
  input  logic [CH_NUM*DATA_W-1:0] adc_data,
  input  logic                     adc_valid,
  input  logic [15:0]              decim,
  input  logic                     arm,
  input  logic [SEL_W-1:0]         trig_ch,
  input  logic [DATA_W-1:0]        trig_level,
  input  logic                     trig_edge,
  input  logic                     force_trig,
  input  logic [ADDR_W-1:0]        pre_len,
  input  logic                     rd_start,
  input  logic                     rd_ready,
  output logic [CH_NUM*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        trig_pos
);

  localparam int WORD_W = CH_NUM * DATA_W;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_ARMED, S_POST, S_DONE, S_READ
  } state_t;

  state_t state_reg, state_next;

  // capture side
  logic [15:0]       dcnt_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic [ADDR_W-1:0] pre_reg;
  logic [ADDR_W-1:0] post_reg;
  logic [ADDR_W-1:0] trig_pos_reg;
  logic [WORD_W-1:0] prev_word_reg;
  logic              prev_vld_reg;
  logic              force_pend_reg;

  // readout side
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [ADDR_W:0]   iss_cnt_reg;
  logic              mem_vld_reg;
  logic              mem_last_reg;
  logic [WORD_W-1:0] mem_q;
  logic [WORD_W-1:0] out_data_reg;
  logic              out_vld_reg;
  logic              out_last_reg;
  logic [WORD_W-1:0] skid_data_reg;
  logic              skid_vld_reg;
  logic              skid_last_reg;

  logic [WORD_W-1:0] mem [DEPTH];

  // ------------------------------------------------------------------
  // Combinational decode
  // ------------------------------------------------------------------
  logic              keep;
  logic              capturing;
  logic              wr_en;
  logic              arm_acc;
  logic              rd_acc;
  logic              edge_hit;
  logic              trig_fire;
  logic              pop;
  logic              issue;
  logic              issue_last;
  logic [1:0]        occ;
  logic [1:0]        occ_after;
  logic [ADDR_W-1:0] cnt_inc;
  logic [ADDR_W-1:0] post_init;
  logic [DATA_W-1:0] cur_sel;
  logic [DATA_W-1:0] prev_sel;
  logic [DATA_W-1:0] cur_ch  [CH_NUM];
  logic [DATA_W-1:0] prev_ch [CH_NUM];

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      assign cur_ch[gi]  = adc_data[gi*DATA_W +: DATA_W];
      assign prev_ch[gi] = prev_word_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign cur_sel  = cur_ch[trig_ch];
  assign prev_sel = prev_ch[trig_ch];

  assign keep      = adc_valid && (dcnt_reg == 16'd0);
  assign capturing = (state_reg == S_FILL) || (state_reg == S_ARMED) || (state_reg == S_POST);
  assign wr_en     = capturing && keep;
  assign arm_acc   = arm && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign rd_acc    = rd_start && !arm && (state_reg == S_DONE);
  assign cnt_inc   = cnt_reg + ADDR_W'(1);
  // DEPTH-1 is all ones, so DEPTH-1-pre is the bitwise complement.
  assign post_init = ~pre_reg;

  // prev_vld_reg is cleared at arm: the first kept sample has no history.
  assign edge_hit = prev_vld_reg &&
                    (trig_edge ? ((prev_sel >= trig_level) && (cur_sel <  trig_level))
                               : ((prev_sel <  trig_level) && (cur_sel >= trig_level)));

  // A force pulse coinciding with a kept sample counts for that sample.
  assign trig_fire = (state_reg == S_ARMED) && keep &&
                     (edge_hit || force_pend_reg || force_trig);

  // Readout: at most two words are ever owned by the pipeline beyond the
  // output register (in-flight RAM read + skid), so a read is only issued when
  // the post-pop occupancy leaves room for it.
  assign pop        = out_vld_reg && rd_ready;
  assign occ        = {1'b0, out_vld_reg} + {1'b0, skid_vld_reg} + {1'b0, mem_vld_reg};
  assign occ_after  = occ - {1'b0, pop};
  assign issue      = (state_reg == S_READ) && !iss_cnt_reg[ADDR_W] && (occ_after < 2'd2);
  assign issue_last = (iss_cnt_reg == {1'b0, {ADDR_W{1'b1}}});

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge ADC_Clk or posedge Reset) begin
    if (Reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // pre_len is ADDR_W bits wide, so it can never exceed DEPTH-1 and the
  // clamp reduces to using it as-is.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (arm) state_next = (pre_len == '0) ? S_ARMED : S_FILL;
      end
      S_FILL: begin
        if (keep && (cnt_inc == pre_reg)) state_next = S_ARMED;
      end
      S_ARMED: begin
        if (trig_fire) state_next = (post_init == '0) ? S_DONE : S_POST;
      end
      S_POST: begin
        if (keep && (post_reg == ADDR_W'(1))) state_next = S_DONE;
      end
      S_DONE: begin
        if (arm)           state_next = (pre_len == '0) ? S_ARMED : S_FILL;
        else if (rd_start) state_next = S_READ;
      end
      S_READ: begin
        if (pop && out_last_reg) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Capture datapath
  // ------------------------------------------------------------------
  always_ff @(posedge ADC_Clk or posedge Reset) begin
    if (Reset) begin
      dcnt_reg       <= '0;
      wr_ptr_reg     <= '0;
      cnt_reg        <= '0;
      pre_reg        <= '0;
      post_reg       <= '0;
      trig_pos_reg   <= '0;
      prev_word_reg  <= '0;
      prev_vld_reg   <= 1'b0;
      force_pend_reg <= 1'b0;
    end else begin
      if (arm_acc)        dcnt_reg <= '0;
      else if (adc_valid) dcnt_reg <= (dcnt_reg == 16'd0) ? decim : dcnt_reg - 16'd1;

      if (arm_acc) begin
        wr_ptr_reg     <= '0;
        cnt_reg        <= '0;
        pre_reg        <= pre_len;
        prev_vld_reg   <= 1'b0;
        force_pend_reg <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr_reg    <= wr_ptr_reg + ADDR_W'(1);
          prev_word_reg <= adc_data;
          prev_vld_reg  <= 1'b1;
        end
        if ((state_reg == S_FILL) && keep) cnt_reg <= cnt_inc;

        // Force requests only survive while ARMED.
        if (state_reg == S_ARMED) begin
          if (trig_fire)       force_pend_reg <= 1'b0;
          else if (force_trig) force_pend_reg <= 1'b1;
        end else begin
          force_pend_reg <= 1'b0;
        end

        if (trig_fire) begin
          trig_pos_reg <= wr_ptr_reg;
          post_reg     <= post_init;
        end else if ((state_reg == S_POST) && keep) begin
          post_reg <= post_reg - ADDR_W'(1);
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Buffer RAM: one write port, registered read
  // ------------------------------------------------------------------
  always_ff @(posedge ADC_Clk) begin
    if (wr_en) mem[wr_ptr_reg] <= adc_data;
    if (issue) mem_q <= mem[rd_addr_reg];
  end

  // ------------------------------------------------------------------
  // Readout pipeline: RAM read -> output register, with a skid register that
  // catches the in-flight word when the output stalls.
  // ------------------------------------------------------------------
  always_ff @(posedge ADC_Clk or posedge Reset) begin
    if (Reset) begin
      rd_addr_reg   <= '0;
      iss_cnt_reg   <= '0;
      mem_vld_reg   <= 1'b0;
      mem_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_vld_reg   <= 1'b0;
      out_last_reg  <= 1'b0;
      skid_data_reg <= '0;
      skid_vld_reg  <= 1'b0;
      skid_last_reg <= 1'b0;
    end else begin
      if (rd_acc) begin
        rd_addr_reg <= trig_pos_reg - pre_reg;
        iss_cnt_reg <= '0;
      end else if (issue) begin
        rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
        iss_cnt_reg <= iss_cnt_reg + (ADDR_W+1)'(1);
      end

      if (state_reg != S_READ) begin
        mem_vld_reg  <= 1'b0;
        out_vld_reg  <= 1'b0;
        skid_vld_reg <= 1'b0;
      end else begin
        mem_vld_reg  <= issue;
        mem_last_reg <= issue_last;
        if (!out_vld_reg || pop) begin
          if (skid_vld_reg) begin
            out_data_reg  <= skid_data_reg;
            out_vld_reg   <= 1'b1;
            out_last_reg  <= skid_last_reg;
            skid_data_reg <= mem_q;
            skid_vld_reg  <= mem_vld_reg;
            skid_last_reg <= mem_last_reg;
          end else begin
            out_data_reg  <= mem_q;
            out_vld_reg   <= mem_vld_reg;
            out_last_reg  <= mem_last_reg;
            skid_vld_reg  <= 1'b0;
          end
        end else if (mem_vld_reg) begin
          skid_data_reg <= mem_q;
          skid_vld_reg  <= 1'b1;
          skid_last_reg <= mem_last_reg;
        end
      end
    end
  end

  assign rd_data  = out_data_reg;
  assign rd_valid = out_vld_reg;
  assign rd_last  = out_vld_reg && out_last_reg;
  assign busy     = capturing || (state_reg == S_READ);
  assign done     = (state_reg == S_DONE);
  assign trig_pos = trig_pos_reg;

endmodule

// File: tb/tb_adc_multich_capture.sv
`timescale 1ns/1ps
module tb_adc_multich_capture;

  localparam int DATA_W = 8;
  localparam int CH_NUM = 4;
  localparam int ADDR_W = 10;
  localparam int SEL_W  = 2;
  localparam int DEPTH  = 1024;
  localparam int WORD_W = 32;

  logic              ADC_Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [WORD_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic [15:0]       decim = '0;
  logic              arm = 1'b0;
  logic [SEL_W-1:0]  trig_ch = '0;
  logic [DATA_W-1:0] trig_level = '0;
  logic              trig_edge = 1'b0;
  logic              force_trig = 1'b0;
  logic [ADDR_W-1:0] pre_len = '0;
  logic              rd_start = 1'b0;
  logic              rd_ready = 1'b0;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] trig_pos;

  adc_multich_capture #(
    .DATA_W(DATA_W), .CH_NUM(CH_NUM), .ADDR_W(ADDR_W), .SEL_W(SEL_W)
  ) dut (
    .ADC_Clk(ADC_Clk), .Reset(Reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .decim(decim), .arm(arm), .trig_ch(trig_ch), .trig_level(trig_level),
    .trig_edge(trig_edge), .force_trig(force_trig), .pre_len(pre_len),
    .rd_start(rd_start), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy), .done(done),
    .trig_pos(trig_pos)
  );

  always #5 ADC_Clk = ~ADC_Clk;

  int total = 0;
  int bad   = 0;

  logic [WORD_W-1:0] exp_q[$];
  logic              exp_last_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Stimulus patterns as a function of raw valid-sample index r since arm.
  //  0: ch0 ramp r, ch1 3r, ch2 r>>8, ch3 0x5A
  //  2: ch0 ramp, ch1 falling ramp, ch2 square (period 16), ch3 0xC0 -> 0x10 at r=300
  //  3: ch0 flat 0x33, ch1 r, ch2 r>>8, ch3 0xA5
  function automatic logic [WORD_W-1:0] gen_word(input int t, input int r);
    logic [7:0] c0, c1, c2, c3;
    int r3;
    r3 = r * 3;
    case (t)
      2: begin
        c0 = r[7:0];
        c1 = ~r[7:0];
        c2 = r[3] ? 8'h00 : 8'hFF;
        c3 = (r < 300) ? 8'hC0 : 8'h10;
      end
      3: begin
        c0 = 8'h33;
        c1 = r[7:0];
        c2 = r[15:8];
        c3 = 8'hA5;
      end
      default: begin
        c0 = r[7:0];
        c1 = r3[7:0];
        c2 = r[15:8];
        c3 = 8'h5A;
      end
    endcase
    return {c3, c2, c1, c0};
  endfunction

  // Scoreboard monitor: pops one expected word per handshake and checks that
  // a stalled word neither changes nor disappears.
  logic              hold_vld = 1'b0;
  logic [WORD_W-1:0] hold_data = '0;

  always @(negedge ADC_Clk) begin
    if (Reset) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        chk("stall_valid", rd_valid, 1);
        if (rd_valid) chk("stall_data", rd_data, hold_data);
      end
      if (rd_valid && rd_ready) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [WORD_W-1:0] e;
          logic              el;
          e  = exp_q.pop_front();
          el = exp_last_q.pop_front();
          $display("word data=%08h last=%0b exp=%08h exp_last=%0b", rd_data, rd_last, e, el);
          chk("rd_data", rd_data, e);
          chk("rd_last", rd_last, el);
        end
        hold_vld = 1'b0;
      end else if (rd_valid) begin
        hold_vld  = 1'b1;
        hold_data = rd_data;
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  // Arm, feed pattern t until done (or stop_at raw samples), then check trig_pos.
  // f_fill / f_arm: raw index before which one force cycle (adc_valid low) is inserted.
  task automatic do_capture(input int id, input int t, input int d, input int pre,
                            input int ch, input int lvl, input int edg,
                            input int f_fill, input int f_arm, input int stop_at,
                            input int exp_trig);
    int r = 0;
    int cyc = 0;
    bit ff_done = 1'b0;
    bit fa_done = 1'b0;
    decim      = 16'(d);
    pre_len    = ADDR_W'(pre);
    trig_ch    = SEL_W'(ch);
    trig_level = DATA_W'(lvl);
    trig_edge  = edg[0];
    adc_valid  = 1'b0;
    arm        = 1'b1;
    @(posedge ADC_Clk); #1;
    arm = 1'b0;
    while (done !== 1'b1 && cyc < 20000) begin
      if (stop_at > 0 && r >= stop_at) break;
      if (!ff_done && r == f_fill) begin
        ff_done = 1'b1; adc_valid = 1'b0; force_trig = 1'b1;
      end else if (!fa_done && r == f_arm) begin
        fa_done = 1'b1; adc_valid = 1'b0; force_trig = 1'b1;
      end else begin
        force_trig = 1'b0;
        adc_valid  = 1'b1;
        adc_data   = gen_word(t, r);
        r++;
      end
      @(posedge ADC_Clk); #1;
      cyc++;
    end
    adc_valid  = 1'b0;
    force_trig = 1'b0;
    if (stop_at == 0) begin
      $display("capture %0d: done=%0b trig_pos=%03h exp=%03h raw=%0d", id, done, trig_pos,
               exp_trig % DEPTH, r);
      chk($sformatf("t%0d_capture_done", id), done, 1);
      chk($sformatf("t%0d_trig_pos", id), trig_pos, exp_trig % DEPTH);
    end
  endtask

  // Expected frame = kept samples trig_idx-pre .. trig_idx-pre+DEPTH-1, oldest first.
  task automatic do_readout(input int id, input int t, input int d, input int pre,
                            input int trig_idx, input bit toggle, input bit hold_arm);
    int vcount = 0;
    int cyc = 0;
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back(gen_word(t, (trig_idx - pre + k) * (d + 1)));
      exp_last_q.push_back(k == DEPTH - 1);
    end
    rd_ready = !toggle;
    rd_start = 1'b1;
    @(posedge ADC_Clk); #1;
    rd_start = 1'b0;
    arm      = hold_arm;
    chk($sformatf("t%0d_valid_lat0", id), rd_valid, 0);
    @(posedge ADC_Clk); #1;
    chk($sformatf("t%0d_valid_lat1", id), rd_valid, 0);
    @(posedge ADC_Clk); #1;
    chk($sformatf("t%0d_valid_lat2", id), rd_valid, 1);
    while (busy && cyc < 5000) begin
      if (rd_valid) vcount++;
      if (toggle) rd_ready = ~rd_ready;
      @(posedge ADC_Clk); #1;
      cyc++;
    end
    arm = 1'b0;
    $display("readout %0d: cycles=%0d valid_cycles=%0d left=%0d", id, cyc, vcount, exp_q.size());
    chk($sformatf("t%0d_read_finished", id), busy, 0);
    chk($sformatf("t%0d_frame_words_left", id), exp_q.size(), 0);
    if (!toggle) chk($sformatf("t%0d_no_bubble", id), vcount, DEPTH);
    @(posedge ADC_Clk); #1;
    chk($sformatf("t%0d_idle_after_read", id), {busy, done}, 0);
    exp_q.delete();
    exp_last_q.delete();
    rd_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge ADC_Clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_last", rd_last, 0);
    chk("reset_trig_pos", trig_pos, 0);
    Reset = 1'b0;
    @(posedge ADC_Clk); #1;

    // 1: ramp on ch0, rising 0x80, pre 4 -> trigger at sample 0x80
    do_capture(1, 0, 0, 4, 0, 8'h80, 0, -1, -1, 0, 128);
    do_readout(1, 0, 0, 4, 128, 1'b0, 1'b0);

    // 2: decim 3 -> kept ch0 steps by 4; rising 0x40 hit at kept 16
    do_capture(2, 0, 3, 2, 0, 8'h40, 0, -1, -1, 0, 16);
    do_readout(2, 0, 3, 2, 16, 1'b0, 1'b0);

    // 3: falling on ch3 only (ch0-2 cross earlier in ARMED)
    do_capture(3, 2, 0, 100, 3, 8'h80, 1, -1, -1, 0, 300);
    do_readout(3, 2, 0, 100, 300, 1'b0, 1'b0);

    // 4: force in FILL ignored, force in ARMED triggers on flat input
    do_capture(4, 3, 0, 20, 0, 8'h80, 0, 5, 50, 0, 50);
    do_readout(4, 3, 0, 20, 50, 1'b0, 1'b0);

    // 5: decim 1, readout with rd_ready toggling
    do_capture(5, 0, 1, 10, 0, 8'h80, 0, -1, -1, 0, 64);
    do_readout(5, 0, 1, 10, 64, 1'b1, 1'b0);

    // 7: pre_len 0 -> straight to ARMED
    do_capture(7, 0, 0, 0, 0, 8'h80, 0, -1, -1, 0, 128);
    do_readout(7, 0, 0, 0, 128, 1'b0, 1'b0);

    // 8: pre_len DEPTH-1 -> no post samples, trigger goes straight to DONE
    do_capture(8, 0, 0, 1023, 0, 8'h80, 0, -1, -1, 0, 1152);
    do_readout(8, 0, 0, 1023, 1152, 1'b0, 1'b0);

    // 6: reset mid-POST, then clean re-capture and readout with arm held
    do_capture(6, 0, 0, 4, 0, 8'h80, 0, -1, -1, 300, 0);
    chk("t6_busy_in_post", busy, 1);
    Reset = 1'b1;
    @(posedge ADC_Clk); #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_rd_valid", rd_valid, 0);
    Reset = 1'b0;
    @(posedge ADC_Clk); #1;
    do_capture(9, 0, 0, 4, 0, 8'h80, 0, -1, -1, 0, 128);
    do_readout(9, 0, 0, 4, 128, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
